// File: rtl/ahbslv_mem.sv
// ahbslv_mem: AHB slave backed by an on-chip SRAM.
// Supports 8/16/32-bit transfers with HSIZE byte lanes, a two-cycle ERROR response,
// write->read forwarding and optional per-transfer wait states (enable with
// `define AHBSLV_WAIT_EN, which adds the I_AHBSLV_WAIT port).
module ahbslv_mem #(
  parameter int unsigned P_ADDR_W = 10,
  parameter logic [31:0] P_BASE   = 32'h0000_0000
) (
  input  logic        I_AHBSLV_HCLK,
  input  logic        I_AHBSLV_HRESET_N,
  input  logic        I_AHBSLV_HSEL,
  input  logic [31:0] I_AHBSLV_HADDR,
  input  logic [1:0]  I_AHBSLV_HTRANS,
  input  logic        I_AHBSLV_HWRITE,
  input  logic [2:0]  I_AHBSLV_HSIZE,
  input  logic [2:0]  I_AHBSLV_HBURST,
  input  logic [31:0] I_AHBSLV_HWDATA,
  input  logic        I_AHBSLV_HREADY,
`ifdef AHBSLV_WAIT_EN
  input  logic [3:0]  I_AHBSLV_WAIT,
`endif
  output logic [31:0] O_AHBSLV_HRDATA,
  output logic        O_AHBSLV_HREADYOUT,
  output logic [1:0]  O_AHBSLV_HRESP
);

  localparam int unsigned IDX_W = P_ADDR_W - 2;
  localparam int unsigned DEPTH = 1 << IDX_W;
  localparam int unsigned LANES = 4;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DATA = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } state_e;

  state_e             state_q;
  logic               ready_q;
  logic [1:0]         resp_q;
  logic [31:0]        rdata_q;
  logic               wr_q;
  logic [IDX_W-1:0]   widx_q;
  logic [LANES-1:0]   be_q;
`ifdef AHBSLV_WAIT_EN
  logic [3:0]         cnt_q;
`endif

  logic [31:0]        mem_q [DEPTH];

  logic               accept_c;
  logic               bad_c;
  logic [IDX_W-1:0]   idx_c;
  logic [LANES-1:0]   be_c;
  logic               commit_c;
  logic [31:0]        merged_c;
  logic [31:0]        rd_word_c;

  // Burst type and the SEQ/NSEQ distinction carry no information for this slave
  logic               unused_c;
  assign unused_c = ^{I_AHBSLV_HBURST, I_AHBSLV_HTRANS[0]};

  // Address-phase decode: acceptance, byte enables and error classification
  always_comb begin
    accept_c = I_AHBSLV_HSEL & I_AHBSLV_HREADY & I_AHBSLV_HTRANS[1];
    idx_c    = I_AHBSLV_HADDR[P_ADDR_W-1:2];
    be_c     = '0;
    case (I_AHBSLV_HSIZE)
      3'b000:  be_c = 4'b0001 << I_AHBSLV_HADDR[1:0];
      3'b001:  be_c = I_AHBSLV_HADDR[1] ? 4'b1100 : 4'b0011;
      3'b010:  be_c = 4'b1111;
      default: be_c = 4'b0000;
    endcase
    bad_c = ((I_AHBSLV_HADDR >> P_ADDR_W) != (P_BASE >> P_ADDR_W))
          | (I_AHBSLV_HSIZE > 3'b010)
          | ((I_AHBSLV_HSIZE == 3'b001) & I_AHBSLV_HADDR[0])
          | ((I_AHBSLV_HSIZE == 3'b010) & (I_AHBSLV_HADDR[1:0] != 2'b00));
  end

  // Pending write merge and read-word selection with forwarding from the live write
  always_comb begin
    commit_c = (state_q == S_DATA) & wr_q;
    merged_c = mem_q[widx_q];
    for (int i = 0; i < int'(LANES); i++) begin
      if (be_q[i]) begin
        merged_c[8*i +: 8] = I_AHBSLV_HWDATA[8*i +: 8];
      end
    end
    if (commit_c && (widx_q == idx_c)) begin
      rd_word_c = merged_c;
    end else begin
      rd_word_c = mem_q[idx_c];
    end
  end

  // Transfer FSM with registered bus outputs
  always_ff @(posedge I_AHBSLV_HCLK or negedge I_AHBSLV_HRESET_N) begin
    if (!I_AHBSLV_HRESET_N) begin
      state_q <= S_IDLE;
      ready_q <= 1'b1;
      resp_q  <= 2'b00;
      rdata_q <= 32'h0;
      wr_q    <= 1'b0;
      widx_q  <= '0;
      be_q    <= '0;
`ifdef AHBSLV_WAIT_EN
      cnt_q   <= 4'd0;
`endif
    end else begin
      case (state_q)
        S_WAIT: begin
`ifdef AHBSLV_WAIT_EN
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= S_DATA;
            ready_q <= 1'b1;
          end
`else
          state_q <= S_DATA;
          ready_q <= 1'b1;
`endif
        end
        S_ERR1: begin
          state_q <= S_ERR2;
          ready_q <= 1'b1;
          resp_q  <= 2'b01;
          rdata_q <= 32'h0;
        end
        default: begin
          // S_IDLE, S_DATA and S_ERR2 all decode a newly accepted address phase
          if (accept_c) begin
            widx_q <= idx_c;
            be_q   <= be_c;
            if (bad_c) begin
              state_q <= S_ERR1;
              ready_q <= 1'b0;
              resp_q  <= 2'b01;
              rdata_q <= 32'h0;
              wr_q    <= 1'b0;
            end else begin
              resp_q  <= 2'b00;
              wr_q    <= I_AHBSLV_HWRITE;
              rdata_q <= I_AHBSLV_HWRITE ? 32'h0 : rd_word_c;
`ifdef AHBSLV_WAIT_EN
              cnt_q   <= I_AHBSLV_WAIT;
              if (I_AHBSLV_WAIT != 4'd0) begin
                state_q <= S_WAIT;
                ready_q <= 1'b0;
              end else begin
                state_q <= S_DATA;
                ready_q <= 1'b1;
              end
`else
              state_q <= S_DATA;
              ready_q <= 1'b1;
`endif
            end
          end else begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
            resp_q  <= 2'b00;
            rdata_q <= 32'h0;
            wr_q    <= 1'b0;
          end
        end
      endcase
    end
  end

  // SRAM array: commit the merged write word at the end of the write data phase
  always_ff @(posedge I_AHBSLV_HCLK) begin
    if (commit_c) begin
      mem_q[widx_q] <= merged_c;
    end
  end

  assign O_AHBSLV_HRDATA    = rdata_q;
  assign O_AHBSLV_HREADYOUT = ready_q;
  assign O_AHBSLV_HRESP     = resp_q;

endmodule

// File: tb/tb_ahbslv_mem.sv
// tb_ahbslv_mem: randomized self-checking bench for ahbslv_mem against a
// sequential word-array model of the SRAM (default parameters: 1KB window at 0).
module tb_ahbslv_mem;

  typedef struct {
    bit        sel;
    bit [1:0]  trans;
    bit        wr;
    bit [31:0] addr;
    bit [2:0]  size;
    bit [31:0] wdata;
    bit [3:0]  wt;
  } txn_t;

  logic        clk;
  logic        rst_n;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic        hready;
  logic [31:0] hrdata;
  logic        hreadyout;
  logic [1:0]  hresp;
`ifdef AHBSLV_WAIT_EN
  logic [3:0]  hwait;
`endif

  int          vectors;
  int          miscompares;
  bit [31:0]   mdl [256];
  bit [31:0]   last_rdata;
  txn_t        q[$];

  assign hready = hreadyout;

  ahbslv_mem dut (
    .I_AHBSLV_HCLK      (clk),
    .I_AHBSLV_HRESET_N  (rst_n),
    .I_AHBSLV_HSEL      (hsel),
    .I_AHBSLV_HADDR     (haddr),
    .I_AHBSLV_HTRANS    (htrans),
    .I_AHBSLV_HWRITE    (hwrite),
    .I_AHBSLV_HSIZE     (hsize),
    .I_AHBSLV_HBURST    (hburst),
    .I_AHBSLV_HWDATA    (hwdata),
    .I_AHBSLV_HREADY    (hready),
`ifdef AHBSLV_WAIT_EN
    .I_AHBSLV_WAIT      (hwait),
`endif
    .O_AHBSLV_HRDATA    (hrdata),
    .O_AHBSLV_HREADYOUT (hreadyout),
    .O_AHBSLV_HRESP     (hresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic txn_t mk(bit [1:0] trans, bit wr, bit [31:0] a, bit [2:0] sz,
                              bit [31:0] d, bit [3:0] wt);
    txn_t t;
    t.sel = 1'b1; t.trans = trans; t.wr = wr; t.addr = a; t.size = sz; t.wdata = d;
`ifdef AHBSLV_WAIT_EN
    t.wt = wt;
`else
    t.wt = 4'd0 & wt;
`endif
    return t;
  endfunction

  function automatic bit pred_err(txn_t t);
    return (t.addr >= 32'd1024) || (t.size > 3'd2) ||
           (t.size == 3'd1 && (t.addr % 2) != 0) ||
           (t.size == 3'd2 && (t.addr % 4) != 0);
  endfunction

  function automatic int widx(bit [31:0] a);
    return int'((a / 4) % 256);
  endfunction

  // Model write: replace the 2**size bytes starting at the addressed lane
  function automatic void mdl_write(txn_t t);
    bit [31:0] w;
    int lane;
    int n;
    w = mdl[widx(t.addr)];
    lane = int'(t.addr % 4);
    n = 1 << t.size;
    for (int b = lane; b < lane + n; b++) w[8*b +: 8] = t.wdata[8*b +: 8];
    mdl[widx(t.addr)] = w;
  endfunction

  task automatic drive_addr(input int i);
    if (i < q.size()) begin
      hsel = q[i].sel; htrans = q[i].trans; haddr = q[i].addr;
      hwrite = q[i].wr; hsize = q[i].size;
`ifdef AHBSLV_WAIT_EN
      hwait = q[i].wt;
`endif
    end else begin
      hsel = 1'b0; htrans = 2'b00; haddr = 32'h0; hwrite = 1'b0; hsize = 3'b000;
`ifdef AHBSLV_WAIT_EN
      hwait = 4'd0;
`endif
    end
    hburst = 3'($urandom_range(0, 7));
  endtask

  // Run the queue as a pipelined AHB master and check every bus cycle
  task automatic run_q(input string name);
    int   cur = -1;
    int   nxt = 0;
    int   k = 0;
    int   budget = 0;
    int   limit;
    bit   rdy;
    bit   err;
    bit   exp_rdy;
    bit [1:0]  exp_resp;
    bit [31:0] exp_d;
    txn_t t;
    limit = 20 * q.size() + 50;
    @(posedge clk); #1;
    drive_addr(0);
    while ((nxt < q.size() || cur >= 0) && budget < limit) begin
      @(negedge clk);
      budget++;
      if (cur >= 0) begin
        t = q[cur];
        err = pred_err(t);
        exp_rdy = err ? (k == 1) : (k == int'(t.wt));
        exp_resp = err ? 2'b01 : 2'b00;
        vectors++;
        if (hreadyout !== exp_rdy || hresp !== exp_resp) begin
          miscompares++;
          $display("FAIL %s txn%0d cyc%0d: hreadyout=%b hresp=%b, required %b %b",
                   name, cur, k, hreadyout, hresp, exp_rdy, exp_resp);
        end
        if (exp_rdy) begin
          exp_d = (!err && !t.wr) ? mdl[widx(t.addr)] : 32'h0;
          vectors++;
          if (hrdata !== exp_d) begin
            miscompares++;
            $display("FAIL %s txn%0d hrdata: got %h, required %h", name, cur, hrdata, exp_d);
          end
          if (!err && !t.wr) last_rdata = hrdata;
          if (!err && t.wr) mdl_write(t);
        end
      end else begin
        vectors++;
        if (hreadyout !== 1'b1 || hresp !== 2'b00 || hrdata !== 32'h0) begin
          miscompares++;
          $display("FAIL %s idle: hreadyout=%b hresp=%b hrdata=%h, required 1 00 0",
                   name, hreadyout, hresp, hrdata);
        end
      end
      rdy = hreadyout;
      @(posedge clk); #1;
      if (rdy) begin
        if (nxt < q.size() && q[nxt].sel && q[nxt].trans[1]) begin
          cur = nxt; k = 0;
        end else begin
          cur = -1;
        end
        if (nxt < q.size()) nxt++;
        drive_addr(nxt);
        hwdata = (cur >= 0) ? q[cur].wdata : $urandom;
      end else begin
        k++;
      end
    end
    if (budget >= limit) begin
      miscompares++;
      $display("FAIL %s timeout: %0d cycles, required below %0d", name, budget, limit);
    end
    q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_addr(0);
    hwdata = 32'h0;
    repeat (2) @(negedge clk);
    vectors++;
    if (hreadyout !== 1'b1 || hresp !== 2'b00 || hrdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset: hreadyout=%b hresp=%b hrdata=%h, required 1 00 0",
               hreadyout, hresp, hrdata);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_init();
    for (int i = 0; i < 256; i++)
      q.push_back(mk((i % 4 == 0) ? 2'b10 : 2'b11, 1'b1, 32'(i * 4), 3'd2, $urandom, 4'd0));
    run_q("init");
  endtask

  task automatic test_word();
    q.push_back(mk(2'b10, 1'b1, 32'h010, 3'd2, 32'hDEADBEEF, 4'd0));
    q.push_back(mk(2'b10, 1'b0, 32'h010, 3'd2, 32'h0, 4'd0));
    run_q("word");
    vectors++;
    if (last_rdata !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL word_rd: got %h, required deadbeef", last_rdata);
    end
  endtask

  task automatic test_lanes();
    q.push_back(mk(2'b10, 1'b1, 32'h010, 3'd2, 32'h0, 4'd0));
    q.push_back(mk(2'b10, 1'b1, 32'h013, 3'd0, 32'hA5A5A5A5, 4'd0));
    q.push_back(mk(2'b10, 1'b0, 32'h010, 3'd2, 32'h0, 4'd0));
    run_q("byte");
    vectors++;
    if (last_rdata !== 32'hA5000000) begin
      miscompares++;
      $display("FAIL byte_rd: got %h, required a5000000", last_rdata);
    end
    q.push_back(mk(2'b10, 1'b1, 32'h010, 3'd2, 32'h0, 4'd0));
    q.push_back(mk(2'b10, 1'b1, 32'h012, 3'd1, 32'h12341234, 4'd0));
    q.push_back(mk(2'b10, 1'b0, 32'h010, 3'd2, 32'h0, 4'd0));
    run_q("half");
    vectors++;
    if (last_rdata !== 32'h12340000) begin
      miscompares++;
      $display("FAIL half_rd: got %h, required 12340000", last_rdata);
    end
  endtask

  task automatic test_back_to_back();
    bit [31:0] d3;
    d3 = $urandom;
    q.push_back(mk(2'b10, 1'b1, 32'h020, 3'd2, $urandom, 4'd0));
    q.push_back(mk(2'b11, 1'b1, 32'h024, 3'd2, $urandom, 4'd0));
    q.push_back(mk(2'b11, 1'b1, 32'h028, 3'd2, $urandom, 4'd0));
    q.push_back(mk(2'b11, 1'b1, 32'h02C, 3'd2, d3, 4'd0));
    q.push_back(mk(2'b10, 1'b0, 32'h02C, 3'd2, 32'h0, 4'd0));
    run_q("b2b");
    vectors++;
    if (last_rdata !== d3) begin
      miscompares++;
      $display("FAIL b2b_fwd: got %h, required %h", last_rdata, d3);
    end
  endtask

  task automatic test_errors();
    bit [31:0] old0;
    old0 = mdl[0];
    q.push_back(mk(2'b10, 1'b0, 32'h001, 3'd1, 32'h0, 4'd0));
    q.push_back(mk(2'b10, 1'b1, 32'h400, 3'd2, ~old0, 4'd0));
    q.push_back(mk(2'b10, 1'b1, 32'h002, 3'd2, ~old0, 4'd0));
    q.push_back(mk(2'b10, 1'b1, 32'h000, 3'd3, ~old0, 4'd0));
    q.push_back(mk(2'b10, 1'b0, 32'h000, 3'd2, 32'h0, 4'd0));
    run_q("err");
    vectors++;
    if (last_rdata !== old0) begin
      miscompares++;
      $display("FAIL err_unchanged: got %h, required %h", last_rdata, old0);
    end
  endtask

  task automatic test_idle_busy();
    txn_t t;
    t = mk(2'b10, 1'b1, 32'h030, 3'd2, $urandom, 4'd0); t.sel = 1'b0; q.push_back(t);
    q.push_back(mk(2'b00, 1'b1, 32'h030, 3'd2, $urandom, 4'd0));
    q.push_back(mk(2'b01, 1'b1, 32'h030, 3'd2, $urandom, 4'd0));
    q.push_back(mk(2'b10, 1'b0, 32'h030, 3'd2, 32'h0, 4'd0));
    q.push_back(mk(2'b01, 1'b0, 32'h034, 3'd2, 32'h0, 4'd0));
    q.push_back(mk(2'b11, 1'b0, 32'h034, 3'd2, 32'h0, 4'd0));
    run_q("idle");
  endtask

  task automatic test_waits();
    q.push_back(mk(2'b10, 1'b1, 32'h050, 3'd2, $urandom, 4'd2));
    q.push_back(mk(2'b10, 1'b0, 32'h050, 3'd2, 32'h0, 4'd3));
    q.push_back(mk(2'b10, 1'b0, 32'h050, 3'd2, 32'h0, 4'd0));
    q.push_back(mk(2'b10, 1'b0, 32'h001, 3'd2, 32'h0, 4'd5));
    q.push_back(mk(2'b10, 1'b0, 32'h054, 3'd2, 32'h0, 4'd15));
    run_q("wait");
  endtask

  task automatic test_reset_abort();
    bit [31:0] old;
    bit        exp_pre;
    old = mdl[16];
    @(posedge clk); #1;
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h040; hwrite = 1'b1; hsize = 3'd2;
`ifdef AHBSLV_WAIT_EN
    hwait = 4'd3;
    exp_pre = 1'b0;
`else
    exp_pre = 1'b1;
`endif
    @(posedge clk); #1;
    drive_addr(0);
    hwdata = ~old;
    @(negedge clk);
    vectors++;
    if (hreadyout !== exp_pre) begin
      miscompares++;
      $display("FAIL abort_pre: hreadyout=%b, required %b", hreadyout, exp_pre);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (hreadyout !== 1'b1 || hresp !== 2'b00 || hrdata !== 32'h0) begin
      miscompares++;
      $display("FAIL abort_rst: hreadyout=%b hresp=%b hrdata=%h, required 1 00 0",
               hreadyout, hresp, hrdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    q.push_back(mk(2'b10, 1'b0, 32'h040, 3'd2, 32'h0, 4'd0));
    run_q("abort");
    vectors++;
    if (last_rdata !== old) begin
      miscompares++;
      $display("FAIL abort_old: got %h, required %h", last_rdata, old);
    end
  endtask

  task automatic test_random();
    txn_t t;
    int   r;
    for (int i = 0; i < 400; i++) begin
      t = mk(2'b10, 1'($urandom_range(0, 1)), 32'h0, 3'd2, $urandom,
             ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 3)) : 4'd0);
      r = $urandom_range(0, 9);
      if (r == 0) begin
        t.sel = 1'b0; t.trans = 2'($urandom_range(0, 3));
      end else if (r == 1) begin
        t.trans = 2'($urandom_range(0, 1));
      end else begin
        t.trans = 2'($urandom_range(2, 3));
      end
      if ($urandom_range(0, 15) == 0) t.addr = $urandom;
      else if ($urandom_range(0, 1) == 1) t.addr = 32'($urandom_range(0, 31));
      else t.addr = 32'($urandom_range(0, 1023));
      t.size = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      if (t.size <= 3'd2 && $urandom_range(0, 3) != 0)
        t.addr = t.addr - (t.addr % (32'd1 << t.size));
      q.push_back(t);
    end
    run_q("rand");
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    last_rdata = 32'h0;
    hwdata = 32'h0;
    test_reset();
    test_init();
    test_word();
    test_lanes();
    test_back_to_back();
    test_errors();
    test_idle_busy();
    test_waits();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
